// File: rtl/passcode_programmer.sv
// passcode_programmer: collects a new BCD passcode twice from keypad events, checks that the
// two entries match, then writes the scrambled code into the stored code register.
// Optional build macro: INACTIVITY_TIMEOUT_EN (aborts an entry after TIMEOUT_CYC idle cycles).
module passcode_programmer #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter logic [15:0] SCRAMBLE_KEY = 16'h5A3C,
    parameter int unsigned TIMEOUT_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_req,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        cancel,
    output logic        load,
    output logic [15:0] datain,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned CODE_W = NUM_DIGITS * 4;
    localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);

    // Reject parameter sets the 16-bit datapath cannot represent.
    if (CODE_W != 16 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("passcode_programmer: NUM_DIGITS*4 must be 16 and TIMEOUT_CYC must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY1 = 3'd1,
        ENTRY2 = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  first_q, first_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               load_q, load_d;
    logic [15:0]        datain_q, datain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               timeout_c;

`ifdef INACTIVITY_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_q, idle_d;
    logic            in_entry_c;

    // Count consecutive quiet cycles while an entry is in progress.
    always_comb begin
        in_entry_c = (state_q == ENTRY1) || (state_q == ENTRY2);
        idle_d     = '0;
        timeout_c  = 1'b0;
        if (in_entry_c && !(digit_valid || enter)) begin
            idle_d    = idle_q + TO_W'(1);
            timeout_c = (idle_q == TO_W'(TIMEOUT_CYC - 1));
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    assign timeout_c = 1'b0;
`endif

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            code_q   <= '0;
            first_q  <= '0;
            count_q  <= '0;
            load_q   <= 1'b0;
            datain_q <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            first_q  <= first_d;
            count_q  <= count_d;
            load_q   <= load_d;
            datain_q <= datain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Next-state, buffer update and registered-output decode.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        first_d = first_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (prog_req) begin
                    state_d = ENTRY1;
                    code_d  = '0;
                    first_d = '0;
                    count_d = '0;
                end
            end
            ENTRY1, ENTRY2: begin
                if (cancel) begin
                    state_d = IDLE;
                    code_d  = '0;
                    first_d = '0;
                    count_d = '0;
                end else if (enter) begin
                    if (count_q != FULL) begin
                        state_d = ERR;
                    end else if (state_q == ENTRY1) begin
                        state_d = ENTRY2;
                        first_d = code_q;
                        code_d  = '0;
                        count_d = '0;
                    end else if (code_q == first_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = ERR;
                    end
                end else if (digit_valid) begin
                    if (digit > 4'd9) begin
                        state_d = ERR;
                    end else if (count_q != FULL) begin
                        code_d  = {code_q[CODE_W-5:0], digit};
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (timeout_c) begin
                    state_d = ERR;
                end
            end
            COMMIT: state_d = DONE;
            DONE:   state_d = IDLE;
            ERR: begin
                state_d = IDLE;
                code_d  = '0;
                first_d = '0;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase

        load_d   = (state_d == COMMIT);
        done_d   = (state_d == DONE);
        error_d  = (state_d == ERR);
        busy_d   = (state_d != IDLE);
        datain_d = (state_d == COMMIT) ? (code_q ^ SCRAMBLE_KEY) : datain_q;
    end

    assign load   = load_q;
    assign datain = datain_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule
